// File: rtl/multi_channel_mem.sv
// multi_channel_mem: parametrised multi-channel memory with a valid/ready
// request interface per channel, a backdoor preload port and saturating
// read/write completion counters.
//
// Handshake: a channel accepts a request on the edge where it is IDLE and
// read_valid or write_valid is high (read wins). Address and data are
// captured only on that edge. The matching ready pulses high for exactly one
// cycle, LATENCY cycles after the accept edge. The channel then waits in
// DRAIN until the requester drops the valid of the completed op, and only
// then can it accept a new request.
module multi_channel_mem #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int LATENCY   = 2,   // legal range 1..15
  parameter int CNT_BITS  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [CHANNELS-1:0]           read_ready,
  output logic [CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [CHANNELS-1:0]           write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [CHANNELS*DATA_BITS-1:0] write_data,
  output logic [CHANNELS-1:0]           write_ready,
  input  logic                          load_en,
  input  logic [ADDR_BITS-1:0]          load_addr,
  input  logic [DATA_BITS-1:0]          load_data,
  output logic [CNT_BITS-1:0]           read_count,
  output logic [CNT_BITS-1:0]           write_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  // Sum width leaves headroom so several channels completing at once can be
  // detected as overflow before saturation.
  localparam int SUM_BITS = CNT_BITS + 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Storage; contents survive reset.
  logic [DATA_BITS-1:0] mem [DEPTH];

  // Per-channel FSM state (visible hierarchically for checkers).
  state_t               state_q [CHANNELS];
  op_t                  op_q    [CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [CHANNELS];
  logic [DATA_BITS-1:0] wdata_q [CHANNELS];
  logic [3:0]           cnt_q   [CHANNELS];

  // Channels entering RESP on the coming edge, split by op.
  logic [CHANNELS-1:0]  rd_done;
  logic [CHANNELS-1:0]  wr_done;
  logic [ADDR_BITS-1:0] commit_addr [CHANNELS];
  logic [DATA_BITS-1:0] commit_data [CHANNELS];

  logic [SUM_BITS-1:0]  rd_sum;
  logic [SUM_BITS-1:0]  wr_sum;
  logic [CNT_BITS-1:0]  rd_next;
  logic [CNT_BITS-1:0]  wr_next;

  // Work out which channels complete on the next edge and with what address/data.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rd_done[c]     = 1'b0;
      wr_done[c]     = 1'b0;
      commit_addr[c] = addr_q[c];
      commit_data[c] = wdata_q[c];
      if (reset) begin
        case (state_q[c])
          ST_IDLE: begin
            // With a one-cycle latency the accept edge is also the RESP edge.
            if (LATENCY == 1) begin
              if (read_valid[c]) begin
                rd_done[c]     = 1'b1;
                commit_addr[c] = read_address[c*ADDR_BITS +: ADDR_BITS];
              end else if (write_valid[c]) begin
                wr_done[c]     = 1'b1;
                commit_addr[c] = write_address[c*ADDR_BITS +: ADDR_BITS];
                commit_data[c] = write_data[c*DATA_BITS +: DATA_BITS];
              end
            end
          end
          ST_WAIT: begin
            if (cnt_q[c] == 4'd1) begin
              if (op_q[c] == OP_READ) rd_done[c] = 1'b1;
              else                    wr_done[c] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating next values for the completion counters.
  always_comb begin
    rd_sum = {{(SUM_BITS-CNT_BITS){1'b0}}, read_count};
    wr_sum = {{(SUM_BITS-CNT_BITS){1'b0}}, write_count};
    for (int c = 0; c < CHANNELS; c++) begin
      rd_sum = rd_sum + SUM_BITS'(rd_done[c]);
      wr_sum = wr_sum + SUM_BITS'(wr_done[c]);
    end
    if (rd_sum[SUM_BITS-1:CNT_BITS] != '0) rd_next = '1;
    else                                   rd_next = rd_sum[CNT_BITS-1:0];
    if (wr_sum[SUM_BITS-1:CNT_BITS] != '0) wr_next = '1;
    else                                   wr_next = wr_sum[CNT_BITS-1:0];
  end

  // Array writes: ascending channel order so the highest channel wins, load last so it beats all.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_done[c]) mem[commit_addr[c]] <= commit_data[c];
    end
    if (load_en) mem[load_addr] <= load_data;
  end

  // Channel FSMs, registered readies, read data capture and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        op_q[c]    <= OP_READ;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      read_ready  <= '0;
      write_ready <= '0;
      read_data   <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      read_count  <= rd_next;
      write_count <= wr_next;
      for (int c = 0; c < CHANNELS; c++) begin
        // Ready is high exactly while the channel sits in RESP.
        read_ready[c]  <= rd_done[c];
        write_ready[c] <= wr_done[c];
        // Nonblocking read of mem gives the pre-write value on a shared edge.
        if (rd_done[c]) read_data[c*DATA_BITS +: DATA_BITS] <= mem[commit_addr[c]];

        case (state_q[c])
          ST_IDLE: begin
            if (read_valid[c]) begin
              op_q[c]    <= OP_READ;
              addr_q[c]  <= read_address[c*ADDR_BITS +: ADDR_BITS];
              cnt_q[c]   <= 4'(LATENCY - 1);
              state_q[c] <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end else if (write_valid[c]) begin
              op_q[c]    <= OP_WRITE;
              addr_q[c]  <= write_address[c*ADDR_BITS +: ADDR_BITS];
              wdata_q[c] <= write_data[c*DATA_BITS +: DATA_BITS];
              cnt_q[c]   <= 4'(LATENCY - 1);
              state_q[c] <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (cnt_q[c] == 4'd1) state_q[c] <= ST_RESP;
            else                  cnt_q[c]   <= cnt_q[c] - 4'd1;
          end
          ST_RESP: begin
            state_q[c] <= ST_DRAIN;
          end
          ST_DRAIN: begin
            // Hold off until the requester has released the completed op.
            if (op_q[c] == OP_READ) begin
              if (!read_valid[c]) state_q[c] <= ST_IDLE;
            end else begin
              if (!write_valid[c]) state_q[c] <= ST_IDLE;
            end
          end
          default: state_q[c] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/multi_channel_mem.md
Name: multi_channel_mem

Overview:
- Synthesizable, parametrised, multi-channel data/program memory.
- Speaks the GPU's valid/ready memory protocol on every channel, so it can stand in for the behavioural memory model in benches and FPGA builds.
- Generalises the fixed model with configurable channel count, depth, data width and response latency.
- Adds a backdoor preload port, deterministic same-address write resolution and saturating access counters.

Parameters:
- ADDR_BITS, 8: address width; depth is 2**ADDR_BITS words.
- DATA_BITS, 8: word width.
- CHANNELS, 4: independent request channels.
- LATENCY, 2: cycles from accept to ready; must be 1..15.
- CNT_BITS, 16: width of the access counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_valid  in  CHANNELS  per-channel read request.
- read_address  in  CHANNELS*ADDR_BITS  channel c occupies slice [c*ADDR_BITS +: ADDR_BITS].
- read_ready  out  CHANNELS  one-cycle read completion pulse.
- read_data  out  CHANNELS*DATA_BITS  read data; valid while read_ready is high.
- write_valid  in  CHANNELS  per-channel write request.
- write_address  in  CHANNELS*ADDR_BITS  write address.
- write_data  in  CHANNELS*DATA_BITS  write data.
- write_ready  out  CHANNELS  one-cycle write completion pulse.
- load_en  in  1  backdoor write strobe.
- load_addr  in  ADDR_BITS  backdoor address.
- load_data  in  DATA_BITS  backdoor data.
- read_count  out  CNT_BITS  completed reads, all channels, saturating.
- write_count  out  CNT_BITS  completed writes, all channels, saturating.

Behaviour:
- Reset (reset low, asynchronous):
  - All channel FSMs go to IDLE.
  - read_ready, write_ready, read_data, read_count and write_count are 0.
  - Array contents are not reset.
- Per-channel FSM states: IDLE, WAIT, RESP, DRAIN.
- IDLE:
  - read_valid=1: latch address, op=READ, load counter with LATENCY-1, go to WAIT (RESP directly if LATENCY=1).
  - Else write_valid=1: latch address and data, op=WRITE, same transition.
  - Read wins when both are asserted. The write stays pending and is accepted after DRAIN if still valid.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
- RESP: the ready for the latched op is high for exactly this cycle, then go to DRAIN.
  - Accept edge is T; ready is high in cycle T+LATENCY.
- DRAIN: stay until the latched op's valid is low, then go to IDLE. A new request is accepted no earlier than the cycle after returning to IDLE.
- Inputs are sampled only at accept. Address or data changes while busy are ignored.
- Read data:
  - Registered on the edge that enters RESP.
  - Taken from array contents before any write committing on that same edge (read-before-write).
  - Held until the next read completion on that channel.
- Write commit: array[addr] <= data on the edge that enters RESP.
- Same-address commits on one edge:
  - Among channels, the highest channel index wins.
  - load_en beats every channel write.
- load_en writes the array on the edge it is sampled. It needs no handshake, is legal at any time, and does not affect FSMs or counters.
- Counters:
  - Incremented on the edge entering RESP, by the number of channels completing that op on that edge (0..CHANNELS).
  - Saturate at all-ones; no wrap.
- Reset asserted mid-transaction aborts the access:
  - A pending write that has not reached RESP is not committed.
  - No ready is emitted after reset releases.
- Channels are fully independent; all CHANNELS may complete on the same cycle.

Test Plan:
- LATENCY=2, load addr 5 = 0x3C, then ch0 read addr 5 accepted at edge T -> read_ready[0]=1 only in cycle T+2, data 0x3C; read_count=1.
- ch1 write addr 9 = 0xA5, drop valid after ready, then ch1 read addr 9 -> returns 0xA5; write_count=1, read_count=1; ch1 readies never high in DRAIN.
- ch0 and ch3 write addr 7 (0x11, 0x22), accepted same edge -> both readies in the same cycle; later read of addr 7 = 0x22; write_count=2.
- Same cycle: ch2 read and ch1 write complete on addr 4 (old 0x00, new 0x77) -> ch2 read_data=0x00; a subsequent read returns 0x77.
- Same cycle: load_en to addr 3 = 0xEE and ch0 write to addr 3 = 0x01 commit -> addr 3 = 0xEE.
- ch0 read_valid and write_valid asserted together -> read completes first, then the write after DRAIN/IDLE. Assert reset mid-WAIT of a write -> no write_ready, array unchanged, counters 0. Force write_count to all-ones with CNT_BITS=4 -> it holds at 0xF.
